mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-requester round-robin arbiter for a single-port memory with
//            1-cycle read latency; requester 1 may lock ownership (bounded).
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0,
    input  logic            req1,
    input  logic            we0,
    input  logic            we1,
    input  logic [AW-1:0]   addr0,
    input  logic [AW-1:0]   addr1,
    input  logic [DW-1:0]   wdata0,
    input  logic [DW-1:0]   wdata1,
    input  logic [DW/8-1:0] wmask0,
    input  logic [DW/8-1:0] wmask1,
    input  logic            lock1,
    output logic            gnt0,
    output logic            gnt1,
    output logic            ack0,
    output logic            ack1,
    output logic [DW-1:0]   rdata0,
    output logic [DW-1:0]   rdata1,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_wmask,
    input  logic [DW-1:0]   mem_rdata,
    output logic            lock_timeout
);

    localparam int c_CNT_W = ($clog2(LOCK_MAX + 1) > 8) ? $clog2(LOCK_MAX + 1) : 8;
    localparam logic [c_CNT_W-1:0] c_LOCK_MAX = c_CNT_W'(LOCK_MAX);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RESP0 = 2'd1;
    localparam logic [1:0] c_RESP1 = 2'd2;

    logic [1:0]         r_state;
    logic               r_last_gnt;
    logic               r_owned;
    logic [c_CNT_W-1:0] r_lock_cnt;
    logic               r_lock_timeout;
    logic               r_lock_block;

    logic w_idle;
    logic w_force;
    logic w_lock_eff;
    logic w_owned_now;
    logic w_owned_next;
    logic w_gnt0;
    logic w_gnt1;

    // Reset masks grants so it dominates any request in the same cycle.
    assign w_idle      = (r_state == c_IDLE) && !reset;
    assign w_force     = r_owned && (r_lock_cnt >= c_LOCK_MAX);
    // After a forced release lock1 is ignored until it has been seen low.
    assign w_lock_eff  = lock1 && !r_lock_block && !w_force;
    assign w_owned_now = r_owned && w_lock_eff;

    assign w_gnt0 = w_idle && req0 && !w_owned_now && (!req1 || r_last_gnt);
    assign w_gnt1 = w_idle && req1 && (w_owned_now || !req0 || !r_last_gnt);

    assign w_owned_next = w_idle ? (w_owned_now || (w_gnt1 && w_lock_eff)) : r_owned;

    assign gnt0         = w_gnt0;
    assign gnt1         = w_gnt1;
    assign ack0         = (r_state == c_RESP0) && !reset;
    assign ack1         = (r_state == c_RESP1) && !reset;
    assign rdata0       = ack0 ? mem_rdata : '0;
    assign rdata1       = ack1 ? mem_rdata : '0;
    assign lock_timeout = r_lock_timeout;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_wmask = '0;
        if (w_gnt0) begin
            mem_addr  = addr0;
            mem_wdata = wdata0;
            mem_we    = we0;
            mem_wmask = wmask0;
        end else if (w_gnt1) begin
            mem_addr  = addr1;
            mem_wdata = wdata1;
            mem_we    = we1;
            mem_wmask = wmask1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_IDLE;
            r_last_gnt     <= 1'b1;
            r_owned        <= 1'b0;
            r_lock_cnt     <= '0;
            r_lock_timeout <= 1'b0;
            r_lock_block   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_gnt0) begin
                        r_state <= c_RESP0;
                    end else if (w_gnt1) begin
                        r_state <= c_RESP1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase

            if (w_gnt0) begin
                r_last_gnt <= 1'b0;
            end else if (w_gnt1) begin
                r_last_gnt <= 1'b1;
            end

            r_owned <= w_owned_next;

            if (!w_owned_next) begin
                r_lock_cnt <= '0;
            end else if (r_owned && (r_lock_cnt < c_LOCK_MAX)) begin
                r_lock_cnt <= r_lock_cnt + c_CNT_W'(1);
            end

            if (w_idle && w_force && lock1) begin
                r_lock_timeout <= 1'b1;
            end

            if (!lock1) begin
                r_lock_block <= 1'b0;
            end else if (w_idle && w_force) begin
                r_lock_block <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed scoreboard bench for mem_arbiter with a 1-cycle memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LM = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, we0, we1, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [3:0]    wmask0, wmask1;
    logic          gnt0, gnt1, ack0, ack1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [3:0]    mem_wmask;
    logic [DW-1:0] mem_rdata;
    logic          lock_timeout;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LM)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .wmask0(wmask0), .wmask1(wmask1), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
        .lock_timeout(lock_timeout)
    );

    logic [31:0] mem [0:255];
    int cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc == 0) mem[4] <= 32'hDEADBEEF;
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wmask[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        mem_rdata <= mem[mem_addr[9:2]];
    end

    typedef struct {
        int          id;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } gnt_t;

    typedef struct {
        int          id;
        bit          rd;
        logic [31:0] data;
    } ack_t;

    gnt_t gq[$];
    ack_t aq[$];
    int   n_chk   = 0;
    int   n_fail  = 0;
    int   gnt_cyc = -10;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_msg(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event not as expected (cycle %0d)", nm, cyc);
    endtask

    // Monitor: pops the expected grant/ack whenever the DUT presents one.
    always @(negedge clk) begin
        gnt_t g;
        ack_t a;
        if (gnt0 || gnt1) begin
            chk("gnt_onehot", 32'(gnt0 && gnt1), 32'd0);
            if (gq.size() == 0) begin
                fail_msg("gnt_unexpected");
            end else begin
                g = gq.pop_front();
                chk("gnt_id", 32'(gnt1), 32'(g.id));
                chk("mem_we", 32'(mem_we), 32'(g.we));
                chk("mem_addr", mem_addr, g.addr);
                chk("mem_wdata", mem_wdata, g.wdata);
                chk("mem_wmask", 32'(mem_wmask), 32'(g.wmask));
            end
            gnt_cyc = cyc;
        end
        if (ack0 || ack1) begin
            chk("ack_onehot", 32'(ack0 && ack1), 32'd0);
            if (aq.size() == 0) begin
                fail_msg("ack_unexpected");
            end else begin
                a = aq.pop_front();
                chk("ack_id", 32'(ack1), 32'(a.id));
                chk("ack_latency", cyc, gnt_cyc + 1);
                if (a.rd) chk("rdata", (a.id == 0) ? rdata0 : rdata1, a.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int n, output int at);
        at = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ((n == 0) ? gnt0 : gnt1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) fail_msg("gnt_wait_timeout");
        tick();
    endtask

    function automatic gnt_t mk_g(int id, logic we, logic [31:0] ad, logic [31:0] wd, logic [3:0] wm);
        gnt_t g;
        g.id = id; g.we = we; g.addr = ad; g.wdata = wd; g.wmask = wm;
        return g;
    endfunction

    function automatic ack_t mk_a(int id, bit rd, logic [31:0] d);
        ack_t a;
        a.id = id; a.rd = rd; a.data = d;
        return a;
    endfunction

    initial begin
        int t, t0, ts, cnt, prev;
        reset = 1'b1; req0 = 1'b1; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; lock1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; wmask0 = '0; wmask1 = '0;

        // Reset with a pending request: no grant allowed.
        tick();
        tick();
        chk("reset_dominates_gnt0", 32'(gnt0), 32'd0);
        reset = 1'b0; req0 = 1'b0;
        tick();
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_gnt1", 32'(gnt1), 32'd0);
        chk("rst_ack0", 32'(ack0), 32'd0);
        chk("rst_ack1", 32'(ack1), 32'd0);
        chk("rst_lock_timeout", 32'(lock_timeout), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);

        // Single CPU read of preloaded word.
        req0 = 1'b1; addr0 = 32'h10;
        gq.push_back(mk_g(0, 1'b0, 32'h10, 32'h0, 4'h0));
        aq.push_back(mk_a(0, 1'b1, 32'hDEADBEEF));
        wait_gnt(0, t);
        req0 = 1'b0; addr0 = '0;
        tick();

        // Loader write, then CPU read-back.
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h12345678; wmask1 = 4'hF;
        gq.push_back(mk_g(1, 1'b1, 32'h20, 32'h12345678, 4'hF));
        aq.push_back(mk_a(1, 1'b0, 32'h0));
        wait_gnt(1, t);
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; wmask1 = '0;
        tick();
        req0 = 1'b1; addr0 = 32'h20;
        gq.push_back(mk_g(0, 1'b0, 32'h20, 32'h0, 4'h0));
        aq.push_back(mk_a(0, 1'b1, 32'h12345678));
        wait_gnt(0, t);
        req0 = 1'b0; addr0 = '0;
        tick();

        // Round-robin from reset: 0,1,0,1 at 2-cycle spacing.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        req0 = 1'b1; addr0 = 32'h10; req1 = 1'b1; addr1 = 32'h20;
        for (int k = 0; k < 2; k++) begin
            gq.push_back(mk_g(0, 1'b0, 32'h10, 32'h0, 4'h0));
            aq.push_back(mk_a(0, 1'b1, 32'hDEADBEEF));
            gq.push_back(mk_g(1, 1'b0, 32'h20, 32'h0, 4'h0));
            aq.push_back(mk_a(1, 1'b1, 32'h12345678));
        end
        cnt = 0; prev = 0;
        for (int i = 0; i < 20 && cnt < 4; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                if (cnt > 0) chk("rr_gap", cyc - prev, 32'd2);
                prev = cyc;
                cnt++;
            end
        end
        if (cnt < 4) fail_msg("rr_grant_count");
        tick();
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Lock: loader keeps ownership until lock1 drops.
        req1 = 1'b1; lock1 = 1'b1; addr1 = 32'h20; addr0 = 32'h10;
        for (int k = 0; k < 3; k++) begin
            gq.push_back(mk_g(1, 1'b0, 32'h20, 32'h0, 4'h0));
            aq.push_back(mk_a(1, 1'b1, 32'h12345678));
        end
        gq.push_back(mk_g(0, 1'b0, 32'h10, 32'h0, 4'h0));
        aq.push_back(mk_a(0, 1'b1, 32'hDEADBEEF));
        wait_gnt(1, t);
        req0 = 1'b1;
        wait_gnt(1, t);
        wait_gnt(1, t);
        lock1 = 1'b0;
        wait_gnt(0, t0);
        chk("lock_release_gnt0_gap", t0 - t, 32'd2);
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Lock timeout with LOCK_MAX = 8.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        req1 = 1'b1; lock1 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            gq.push_back(mk_g(1, 1'b0, 32'h20, 32'h0, 4'h0));
            aq.push_back(mk_a(1, 1'b1, 32'h12345678));
        end
        gq.push_back(mk_g(0, 1'b0, 32'h10, 32'h0, 4'h0));
        aq.push_back(mk_a(0, 1'b1, 32'hDEADBEEF));
        wait_gnt(1, ts);
        chk("timeout_before", 32'(lock_timeout), 32'd0);
        req0 = 1'b1;
        wait_gnt(0, t0);
        chk("timeout_gnt0_within_10", 32'((t0 - ts) <= 10), 32'd1);
        chk("timeout_flag_set", 32'(lock_timeout), 32'd1);
        req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
        tick();
        tick();
        tick();
        chk("timeout_sticky", 32'(lock_timeout), 32'd1);

        // Reset during RESP0 aborts the ack.
        req0 = 1'b1; addr0 = 32'h10;
        gq.push_back(mk_g(0, 1'b0, 32'h10, 32'h0, 4'h0));
        wait_gnt(0, t);
        reset = 1'b1; req0 = 1'b0; addr0 = '0;
        @(negedge clk);
        chk("abort_no_ack0", 32'(ack0), 32'd0);
        tick();
        reset = 1'b0;
        chk("post_abort_gnt0", 32'(gnt0), 32'd0);
        chk("post_abort_gnt1", 32'(gnt1), 32'd0);
        chk("post_abort_ack0", 32'(ack0), 32'd0);
        chk("post_abort_ack1", 32'(ack1), 32'd0);
        chk("post_abort_mem_we", 32'(mem_we), 32'd0);
        chk("post_abort_rdata0", rdata0, 32'd0);
        chk("post_abort_timeout_cleared", 32'(lock_timeout), 32'd0);

        tick();
        tick();
        chk("gnt_queue_drained", gq.size(), 32'd0);
        chk("ack_queue_drained", aq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
